// File: rtl/bus_pkg.sv
// Shared bus definitions for the client/server rq-ack protocol.
// Holds the responder FSM encoding and the read/write direction codes.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } bus_state_t;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

endpackage

// File: rtl/server_if.sv
// Granted-client bus as seen by a server.
// master: drives address/rq/wr_ni/dataW; slave: drives ack/dataR/err/busy.
interface server_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  rq;
    logic                  wr_ni;
    logic [DATA_WIDTH-1:0] dataW;
    logic                  ack;
    logic [DATA_WIDTH-1:0] dataR;
    logic                  err;
    logic                  busy;

    modport master (
        output address, rq, wr_ni, dataW,
        input  ack, dataR, err, busy
    );

    modport slave (
        input  address, rq, wr_ni, dataW,
        output ack, dataR, err, busy
    );
endinterface

// File: rtl/server_control_logic.sv
// Server FSM: wait-state counter plus ack/err/busy and access strobes.
// Ports: clk, reset (async low), rq, in_range -> ack, err, busy, capture, access, direct.
module server_control_logic #(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic rq,
    input  logic in_range,
    output logic ack,
    output logic err,
    output logic busy,
    output logic capture,
    output logic access,
    output logic direct
);
    import bus_pkg::*;

    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD =
        NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    bus_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        access    = 1'b0;
        direct    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rq) begin
                    capture = 1'b1;
                    if (NO_WAIT) begin
                        // No latch yet: access uses the live bus
                        access    = 1'b1;
                        direct    = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        cnt_nxt   = WS_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!rq) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ack  = (state == ACK);
    assign err  = ack && !in_range;
    assign busy = (state != IDLE);

endmodule

// File: rtl/server.sv
// Bus responder owning a register file for [ADDR_SPACE_BEGINNING, ADDR_SPACE_END].
// Ports: clk, reset (async low), bus (server_if.slave: address/rq/wr_ni/dataW in, ack/dataR/err/busy out).
module server #(
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 3,
    parameter int WAIT_STATES          = 1
) (
    input logic      clk,
    input logic      reset,
    server_if.slave  bus
);
    import bus_pkg::*;

    localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE =
        ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_wr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  capture, access, direct;
    logic [ADDR_WIDTH-1:0] acc_addr, acc_idx, lat_idx;
    logic                  acc_wr, acc_hit, lat_hit;
    logic [DATA_WIDTH-1:0] acc_data;

    // Subtracting the base wraps addresses below it to large
    // indices, so a single upper-bound test covers both ends.
    assign acc_addr = direct ? bus.address : lat_addr;
    assign acc_wr   = direct ? bus.wr_ni   : lat_wr;
    assign acc_data = direct ? bus.dataW   : lat_data;
    assign acc_idx  = acc_addr - BASE;
    assign acc_hit  = (acc_idx <= LAST);
    assign lat_idx  = lat_addr - BASE;
    assign lat_hit  = (lat_idx <= LAST);

    server_control_logic #(
        .WAIT_STATES (WAIT_STATES)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .rq       (bus.rq),
        .in_range (lat_hit),
        .ack      (bus.ack),
        .err      (bus.err),
        .busy     (bus.busy),
        .capture  (capture),
        .access   (access),
        .direct   (direct)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr <= '0;
            lat_wr   <= BUS_WRITE;
            lat_data <= '0;
            data_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (capture) begin
                lat_addr <= bus.address;
                lat_wr   <= bus.wr_ni;
                lat_data <= bus.dataW;
            end
            if (access) begin
                if (acc_hit) begin
                    if (acc_wr == BUS_READ) begin
                        data_r <= mem[acc_idx[IDX_W-1:0]];
                    end else begin
                        mem[acc_idx[IDX_W-1:0]] <= acc_data;
                    end
                end else if (acc_wr == BUS_READ) begin
                    data_r <= '0;
                end
            end
        end
    end

    assign bus.dataR = data_r;

endmodule
